// File: rtl/mc68000_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc68000_bus_pkg
// Brief    : Shared state encoding and limits for the mc68000 bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mc68000_bus_pkg;

    localparam int c_max_n_req = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_BUS = 3'd2,
        OWN      = 3'd3,
        REL      = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mc68000_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first set bit at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mc68000_bus_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int OW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    ptr,
    output logic [OW-1:0]    idx,
    output logic             any
);

    localparam logic [OW:0] c_n = (OW+1)'(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [OW-1:0]      w_off;
    logic [OW:0]        w_sum;

    // Rotating a doubled vector puts index ptr at bit 0, so the lowest set
    // bit gives the distance from ptr to the winner.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = OW'(i);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= c_n) ? OW'(w_sum - c_n) : w_sum[OW-1:0];
    assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/mc68000_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mc68000_bus_arbiter
// Brief    : Round-robin BR/BG/BGACK bus-mastership arbiter with hold limit.
// Revision : 1.0 - initial release
// ============================================================================
module mc68000_bus_arbiter
    import mc68000_bus_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 200,
    parameter int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_n,
    output logic [N_REQ-1:0] gnt_n,
    output logic             cpu_br_n,
    input  logic             cpu_bg_n,
    input  logic             as_n,
    output logic             bgack_n,
    output logic [OW-1:0]    owner,
    output logic             timeout
);

    localparam logic [15:0]   c_cnt_last = 16'(TIMEOUT - 1);
    localparam logic [OW-1:0] c_last_idx = OW'(N_REQ - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [OW-1:0]    r_owner, w_owner_nxt;
    logic [OW-1:0]    r_ptr, w_ptr_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt_n, w_gnt_n_nxt;
    logic             r_br_n, w_br_n_nxt;
    logic             r_bgack_n, w_bgack_n_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [OW-1:0]    w_pick;
    logic             w_any;
    logic             w_owner_drop;
    logic [OW-1:0]    w_ptr_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_rr_pick (
        .req (~req_n),
        .ptr (r_ptr),
        .idx (w_pick),
        .any (w_any)
    );

    assign w_owner_drop = req_n[r_owner];
    assign w_ptr_inc    = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_n_nxt   = r_gnt_n;
        w_br_n_nxt    = r_br_n;
        w_bgack_n_nxt = r_bgack_n;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_br_n_nxt  = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (w_owner_drop) begin
                    w_br_n_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!cpu_bg_n) begin
                    w_state_nxt = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                // Wait for the CPU to finish any cycle in flight; no hold limit here.
                if (w_owner_drop) begin
                    w_br_n_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (as_n) begin
                    w_bgack_n_nxt = 1'b0;
                    w_br_n_nxt    = 1'b1;
                    w_gnt_n_nxt   = ~(N_REQ'(1) << r_owner);
                    w_cnt_nxt     = '0;
                    w_state_nxt   = OWN;
                end
            end
            OWN: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (w_owner_drop || (r_cnt == c_cnt_last)) begin
                    w_timeout_nxt = !w_owner_drop;
                    w_gnt_n_nxt   = '1;
                    w_bgack_n_nxt = 1'b1;
                    w_ptr_nxt     = w_ptr_inc;
                    w_state_nxt   = REL;
                end
            end
            REL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt_n   <= '1;
            r_br_n    <= 1'b1;
            r_bgack_n <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt_n   <= w_gnt_n_nxt;
            r_br_n    <= w_br_n_nxt;
            r_bgack_n <= w_bgack_n_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt_n    = r_gnt_n;
    assign cpu_br_n = r_br_n;
    assign bgack_n  = r_bgack_n;
    assign owner    = r_owner;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mc68000_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc68000_bus_arbiter
// Brief    : Scoreboard bench: timed transactions predict BR and grant events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc68000_bus_arbiter;

    localparam int N = 2;
    localparam int T = 8;

    typedef struct {
        int fall;
        int rise;
    } br_t;

    typedef struct {
        int m;
        int start;
        int len;
        bit tmo;
    } gnt_t;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic [N-1:0] req_n    = '1;
    logic         cpu_bg_n = 1'b1;
    logic         as_n     = 1'b1;
    logic [N-1:0] gnt_n;
    logic         cpu_br_n;
    logic         bgack_n;
    logic [0:0]   owner;
    logic         timeout;

    int  cyc      = 0;
    int  checks   = 0;
    int  errors   = 0;
    bit  mon_en   = 1'b0;
    int  ptr_m    = 0;
    int  tmo_exp  = 0;
    int  tmo_seen = 0;
    br_t  q_br[$];
    gnt_t q_gnt[$];

    mc68000_bus_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (T)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_n    (req_n),
        .gnt_n    (gnt_n),
        .cpu_br_n (cpu_br_n),
        .cpu_bg_n (cpu_bg_n),
        .as_n     (as_n),
        .bgack_n  (bgack_n),
        .owner    (owner),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Reference: first requesting index scanning upward from the pointer.
    function automatic int pick(input int mask, input int p);
        for (int k = 0; k < N; k++) begin
            if (((mask >> ((p + k) % N)) & 1) == 1) return (p + k) % N;
        end
        return -1;
    endfunction

    // One request episode starting at the current negedge with the arbiter idle.
    // ab >= 0 selects an abort (0: while requesting, 1: after bus grant seen).
    task automatic run_txn(input int mask, input int d1, input int a,
                           input int h, input int ab, output int nxt);
        int   c0, w, g, r;
        br_t  b;
        gnt_t e;
        c0    = cyc;
        w     = pick(mask, ptr_m);
        req_n = ~mask[N-1:0];
        if (ab >= 0) begin
            b.fall = c0 + 1;
            b.rise = c0 + 2 + ab;
            q_br.push_back(b);
            wait_until(c0 + 1);
            if (ab == 1) begin
                cpu_bg_n = 1'b0;
                as_n     = 1'b0;
                wait_until(c0 + 2);
            end
            req_n    = '1;
            cpu_bg_n = 1'b1;
            as_n     = 1'b1;
            nxt      = b.rise;
        end else begin
            g      = c0 + d1 + 2 + a;
            b.fall = c0 + 1;
            b.rise = g;
            q_br.push_back(b);
            e.m     = w;
            e.start = g;
            e.len   = (h > T) ? T : h;
            e.tmo   = (h > T);
            q_gnt.push_back(e);
            if (h > T) tmo_exp++;
            wait_until(c0 + d1);
            cpu_bg_n = 1'b0;
            as_n     = (a > 0) ? 1'b0 : 1'b1;
            if (a > 0) begin
                wait_until(c0 + d1 + 1);
                cpu_bg_n = 1'b1;
                wait_until(c0 + d1 + 1 + a);
                as_n = 1'b1;
            end
            wait_until(g);
            cpu_bg_n = 1'b1;
            r = g + h - 1;
            wait_until(r);
            req_n = '1;
            ptr_m = (w + 1) % N;
            nxt   = r + 2;
        end
    endtask

    initial begin : monitor
        logic         pbr;
        logic [N-1:0] pg;
        logic [N-1:0] ev;
        br_t          cb;
        gnt_t         cg;
        int           st;
        pbr = 1'b1;
        pg  = '1;
        st  = 0;
        cb.fall = 0; cb.rise = 0;
        cg.m = 0; cg.start = 0; cg.len = 0; cg.tmo = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (timeout) tmo_seen++;
                if (pbr && !cpu_br_n) begin
                    if (q_br.size() == 0) check("br_unexpected_fall", cyc, -1);
                    else begin
                        cb = q_br.pop_front();
                        check("br_fall_cycle", cyc, cb.fall);
                    end
                end
                if (!pbr && cpu_br_n) check("br_rise_cycle", cyc, cb.rise);
                if (pg == '1 && gnt_n != '1) begin
                    if (q_gnt.size() == 0) check("gnt_unexpected", cyc, -1);
                    else begin
                        cg = q_gnt.pop_front();
                        ev = '1;
                        ev[cg.m] = 1'b0;
                        check("gnt_vector", int'(gnt_n), int'(ev));
                        check("gnt_owner", int'(owner), cg.m);
                        check("gnt_start_cycle", cyc, cg.start);
                        check("gnt_bgack_low", int'(bgack_n), 0);
                        st = cyc;
                    end
                end
                if (pg != '1 && gnt_n == '1) begin
                    check("gnt_length", cyc - st, cg.len);
                    check("gnt_timeout_flag", int'(timeout), int'(cg.tmo));
                    check("rel_bgack_high", int'(bgack_n), 1);
                end
            end
            pbr = cpu_br_n;
            pg  = gnt_n;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int dt[7][5] = '{
            '{3, 1, 0, 3, -1},
            '{3, 2, 0, 2, -1},
            '{1, 1, 5, 4, -1},
            '{1, 1, 0, 9, -1},
            '{2, 1, 0, 8, -1},
            '{1, 0, 0, 0, 0},
            '{2, 0, 0, 0, 1}
        };
        int  next;
        int  ab;
        int  k;
        bit  tseen;
        repeat (3) @(negedge clk);
        check("rst_br_n", int'(cpu_br_n), 1);
        check("rst_bgack_n", int'(bgack_n), 1);
        check("rst_gnt_n", int'(gnt_n), 3);
        check("rst_timeout", int'(timeout), 0);
        check("rst_owner", int'(owner), 0);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        next   = cyc;

        for (int i = 0; i < 7; i++) begin
            wait_until(next);
            run_txn(dt[i][0], dt[i][1], dt[i][2], dt[i][3], dt[i][4], next);
            next += $urandom_range(0, 2);
        end
        for (int i = 0; i < 40; i++) begin
            wait_until(next);
            ab = ($urandom_range(0, 5) < 2) ? int'($urandom_range(0, 1)) : -1;
            run_txn(int'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(1, 3)),
                    ($urandom_range(0, 4) == 0) ? 5 : int'($urandom_range(0, 2)),
                    int'($urandom_range(1, T + 1)), ab, next);
            next += $urandom_range(0, 3);
        end
        // Leave the pointer at 1 so the post-reset grant shows it was cleared.
        wait_until(next);
        run_txn(1, 1, 0, 2, -1, next);
        wait_until(next + 4);
        check("br_queue_drained", q_br.size(), 0);
        check("gnt_queue_drained", q_gnt.size(), 0);
        check("timeout_pulses", tmo_seen, tmo_exp);

        // Asynchronous reset while master 0 owns the bus.
        mon_en   = 1'b0;
        req_n    = 2'b10;
        cpu_bg_n = 1'b0;
        as_n     = 1'b1;
        k = 0;
        while (gnt_n == '1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("own_reached", int'(gnt_n), 2);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_gnt_n", int'(gnt_n), 3);
        check("arst_bgack_n", int'(bgack_n), 1);
        check("arst_br_n", int'(cpu_br_n), 1);
        check("arst_owner", int'(owner), 0);
        tseen = timeout;
        req_n    = '1;
        cpu_bg_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tseen |= timeout;
        end
        check("arst_no_timeout", int'(tseen), 0);
        reset_n = 1'b1;
        ptr_m   = 0;
        @(negedge clk);
        mon_en = 1'b1;
        run_txn(3, 1, 0, 2, -1, next);
        wait_until(next + 4);
        check("final_br_queue", q_br.size(), 0);
        check("final_gnt_queue", q_gnt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
